// File: rtl/d_flip_flop_sync_reset_pkg.sv
// ---------------------------------------------------------------------------
// dff_pkg
//
// Shared definitions for the d_flip_flop_sync_reset register slice.
//
// Contents:
//   DFF_MAX_WIDTH           - widest bus a single register instance may hold
//   DFF_DEFAULT_RESET_VALUE - all-zero reset pattern, sliced to WIDTH by users
//   dff_ctrl_t              - packed {clr, en} control pair seen by every bit
//   dff_next_bit()          - next-state function of one storage bit
//
// Optional feature macro used elsewhere in this slice: DFF_QN_OUTPUT_EN.
// ---------------------------------------------------------------------------
package dff_pkg;

    localparam int DFF_MAX_WIDTH = 64;

    localparam logic [DFF_MAX_WIDTH-1:0] DFF_DEFAULT_RESET_VALUE = '0;

    // Control pair shared by all bits; clr is the MSB so the pair reads
    // in priority order.
    typedef struct packed {
        logic clr;
        logic en;
    } dff_ctrl_t;

    // Next value of one bit on a rising clock edge while reset is released.
    // The default arm is only reachable when clr or en carry X/Z; returning
    // X there keeps an unknown control from being mistaken for a 0.
    function automatic logic dff_next_bit(
        input dff_ctrl_t ctrl,
        input logic      d,
        input logic      q
    );
        logic result;
        case ({ctrl.clr, ctrl.en})
            2'b10,
            2'b11:   result = 1'b0;
            2'b01:   result = d;
            2'b00:   result = q;
            default: result = 1'bx;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/d_flip_flop_sync_reset_if.sv
// ---------------------------------------------------------------------------
// d_flip_flop_sync_reset_if
//
// Bundles the data and control signals of one d_flip_flop_sync_reset
// instance. Clock and reset stay outside as plain ports of the register.
//
// Parameters:
//   WIDTH - data width in bits
//
// Signals:
//   en   - load enable, active-high
//   clr  - synchronous clear, active-high
//   d    - data to capture
//   q    - registered data
//   q_n  - complement of q (only when DFF_QN_OUTPUT_EN is defined)
//
// Modports:
//   master - the block driving the register (drives en/clr/d, reads q)
//   slave  - the register itself (reads en/clr/d, drives q)
// ---------------------------------------------------------------------------
interface d_flip_flop_sync_reset_if #(
    parameter int WIDTH = 1
);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
`ifdef DFF_QN_OUTPUT_EN
    logic [WIDTH-1:0] q_n;
`endif

    modport master (
        output en,
        output clr,
        output d,
        input  q
`ifdef DFF_QN_OUTPUT_EN
        ,
        input  q_n
`endif
    );

    modport slave (
        input  en,
        input  clr,
        input  d,
        output q
`ifdef DFF_QN_OUTPUT_EN
        ,
        output q_n
`endif
    );

endinterface

// File: rtl/d_flip_flop_sync_reset_bit_cell.sv
// ---------------------------------------------------------------------------
// dff_bit_cell
//
// One bit of storage for d_flip_flop_sync_reset.
//
// Parameters:
//   RESET_VALUE - value forced onto q while reset is low
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   ctrl  - {clr, en} shared control pair
//   d     - data bit to capture
//   q     - stored bit
//
// Priority: reset low > clr > en > hold.
// ---------------------------------------------------------------------------
module dff_bit_cell
    import dff_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  dff_ctrl_t ctrl,
    input  logic      d,
    output logic      q
);

    logic next_q;

    always_comb begin
        next_q = dff_next_bit(ctrl, d, q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= next_q;
        end
    end

endmodule

// File: rtl/d_flip_flop_sync_reset.sv
// ---------------------------------------------------------------------------
// d_flip_flop_sync_reset
//
// Parameterised D register with load enable, synchronous clear and an
// asynchronous active-low reset to a configurable value. With the default
// WIDTH=1 it is a plain single-bit D flip-flop (tie en high, clr low).
//
// Parameters:
//   WIDTH       - data width in bits, 1..DFF_MAX_WIDTH
//   RESET_VALUE - value loaded into q while reset is low
//
// Ports:
//   clk   - rising-edge clock, the only clock
//   reset - asynchronous, active-low reset
//   bus   - slave side of d_flip_flop_sync_reset_if: en, clr, d in; q out
//           (plus q_n out when DFF_QN_OUTPUT_EN is defined)
//
// Build option: DFF_QN_OUTPUT_EN adds q_n = ~q, taken straight from the
// stored bits so it also reads ~RESET_VALUE during reset.
//
// The interface instance connected to bus must use the same WIDTH.
// ---------------------------------------------------------------------------
module d_flip_flop_sync_reset
    import dff_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = DFF_DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
    input  logic                        clk,
    input  logic                        reset,
    d_flip_flop_sync_reset_if.slave     bus
);

    if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_width_check
        $error("d_flip_flop_sync_reset: WIDTH=%0d outside 1..%0d",
               WIDTH, DFF_MAX_WIDTH);
    end

    dff_ctrl_t        ctrl;
    logic [WIDTH-1:0] q_bits;

    assign ctrl.clr = bus.clr;
    assign ctrl.en  = bus.en;

    // Every bit is an independent cell; only the control pair is shared.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .ctrl  (ctrl),
            .d     (bus.d[i]),
            .q     (q_bits[i])
        );
    end

    assign bus.q = q_bits;

`ifdef DFF_QN_OUTPUT_EN
    assign bus.q_n = ~q_bits;
`endif

endmodule

// File: tb/tb_d_flip_flop_sync_reset.sv
// ---------------------------------------------------------------------------
// tb_d_flip_flop_sync_reset
//
// Self-checking bench for d_flip_flop_sync_reset. Two instances run off one
// 6 ns clock: a 1-bit register with reset value 0 and an 8-bit register with
// reset value 8'hA5. q_n is checked only when DFF_QN_OUTPUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_d_flip_flop_sync_reset;

    logic clk;
    logic reset1;
    logic reset8;

    int total_checks = 0;
    int bad_checks   = 0;

    d_flip_flop_sync_reset_if #(.WIDTH(1)) bus1 ();
    d_flip_flop_sync_reset_if #(.WIDTH(8)) bus8 ();

    d_flip_flop_sync_reset #(
        .WIDTH       (1),
        .RESET_VALUE (1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    d_flip_flop_sync_reset #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .bus   (bus8)
    );

    initial begin
        clk = 1'b0;
        forever #3 clk = ~clk;
    end

    typedef struct {
        logic  en;
        logic  clr;
        logic  d;
        logic  exp_q;
        string name;
    } vec_t;

    vec_t vecs [12];

    task automatic applyStimulus(input logic en, input logic clr, input logic d);
        bus1.en  = en;
        bus1.clr = clr;
        bus1.d   = d;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        vecs[0]  = '{en: 1'b1, clr: 1'b0, d: 1'b1, exp_q: 1'b1, name: "capture_1"};
        vecs[1]  = '{en: 1'b1, clr: 1'b0, d: 1'b0, exp_q: 1'b0, name: "capture_0"};
        vecs[2]  = '{en: 1'b1, clr: 1'b0, d: 1'b1, exp_q: 1'b1, name: "capture_1b"};
        vecs[3]  = '{en: 1'b0, clr: 1'b0, d: 1'b0, exp_q: 1'b1, name: "hold_edge1"};
        vecs[4]  = '{en: 1'b0, clr: 1'b0, d: 1'b0, exp_q: 1'b1, name: "hold_edge2"};
        vecs[5]  = '{en: 1'b0, clr: 1'b0, d: 1'b0, exp_q: 1'b1, name: "hold_edge3"};
        vecs[6]  = '{en: 1'b1, clr: 1'b0, d: 1'b0, exp_q: 1'b0, name: "enable_again"};
        vecs[7]  = '{en: 1'b1, clr: 1'b0, d: 1'b1, exp_q: 1'b1, name: "reload_1"};
        vecs[8]  = '{en: 1'b1, clr: 1'b1, d: 1'b1, exp_q: 1'b0, name: "clr_over_en"};
        vecs[9]  = '{en: 1'b1, clr: 1'b0, d: 1'b1, exp_q: 1'b1, name: "after_clr"};
        vecs[10] = '{en: 1'b0, clr: 1'b1, d: 1'b1, exp_q: 1'b0, name: "clr_without_en"};
        vecs[11] = '{en: 1'b1, clr: 1'b0, d: 1'b1, exp_q: 1'b1, name: "final_load"};

        reset1 = 1'b1;
        reset8 = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        bus8.en  = 1'b1;
        bus8.clr = 1'b0;
        bus8.d   = 8'hFF;

        // Falling edge on both resets before the first clock edge.
        #1;
        reset1 = 1'b0;
        reset8 = 1'b0;
        #1;
        checkOutput("reset_q1", 64'(bus1.q), 64'h0);
        checkOutput("reset_q8", 64'(bus8.q), 64'hA5);
`ifdef DFF_QN_OUTPUT_EN
        checkOutput("reset_qn8", 64'(bus8.q_n), 64'h5A);
`endif

        // Clock edges while reset is held must not capture d.
        @(posedge clk);
        #1;
        checkOutput("reset_hold_q1", 64'(bus1.q), 64'h0);
        checkOutput("reset_hold_q8", 64'(bus8.q), 64'hA5);

        $display("[TB] 1-bit vector table");
        @(negedge clk);
        reset1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].d);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, 64'(bus1.q), 64'(vecs[i].exp_q));
        end

        // d moving between edges must not reach q.
        applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("no_comb_path", 64'(bus1.q), 64'h1);

        // Async reset lands between edges, well before the next rising edge.
        reset1 = 1'b0;
        #1;
        checkOutput("async_reset_now", 64'(bus1.q), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("async_reset_held", 64'(bus1.q), 64'h0);

        // Release coinciding with a rising edge: the flop must see the
        // pre-edge (low) reset on that edge, hence the nonblocking update.
        @(posedge clk);
        reset1 <= 1'b1;
        #1;
        checkOutput("release_edge_no_capture", 64'(bus1.q), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("release_next_edge", 64'(bus1.q), 64'h1);

        $display("[TB] 8-bit sequence");
        @(negedge clk);
        reset8   = 1'b1;
        bus8.en  = 1'b1;
        bus8.clr = 1'b0;
        bus8.d   = 8'h3C;
        @(posedge clk);
        #1;
        checkOutput("w8_capture", 64'(bus8.q), 64'h3C);
`ifdef DFF_QN_OUTPUT_EN
        checkOutput("w8_capture_qn", 64'(bus8.q_n), 64'hC3);
`endif
        @(negedge clk);
        bus8.en = 1'b0;
        bus8.d  = 8'hFF;
        @(posedge clk);
        #1;
        checkOutput("w8_hold", 64'(bus8.q), 64'h3C);
        @(negedge clk);
        bus8.clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("w8_clear", 64'(bus8.q), 64'h00);
        @(negedge clk);
        bus8.clr = 1'b0;
        bus8.en  = 1'b1;
        bus8.d   = 8'h81;
        @(posedge clk);
        #1;
        checkOutput("w8_load_81", 64'(bus8.q), 64'h81);
        #1;
        reset8 = 1'b0;
        #1;
        checkOutput("w8_async_reset", 64'(bus8.q), 64'hA5);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/d_flip_flop_sync_reset.md
# d_flip_flop_sync_reset

Parameterised edge-triggered D register with load enable and synchronous clear, used as the basic storage element wherever the design needs a one-cycle registered copy of a signal bus. It captures `d` on every rising `clk` edge while enabled. An asynchronous active-low reset forces a configurable reset value. The default configuration (WIDTH=1) is a plain single-bit D flip-flop.

## Interface
- `WIDTH`, default 1: data width in bits, range 1..64.
- `RESET_VALUE`, default 0 (all bits): value loaded into `q` while reset is asserted, WIDTH bits.
- `clk`  input  1  rising-edge clock; the only clock.
- `reset`  input  1  reset, asynchronous and active-low.
- `en`  input  1  load enable, active-high; tie high for a plain DFF.
- `clr`  input  1  synchronous clear, active-high.
- `d`  input  WIDTH  data to capture.
- `q`  output  WIDTH  registered data.
- `q_n`  output  WIDTH  bitwise complement of `q`; present only with `DFF_QN_OUTPUT_EN`.

## Operation
- Priority, highest first: reset low > `clr` > `en` > hold.
- `reset` low: `q` = RESET_VALUE at once, independent of `clk`. `q` holds that value for as long as `reset` stays low.
- `reset` high, rising `clk`, `clr`=1: `q` <= 0. This happens regardless of `en` and `d`.
- `reset` high, rising `clk`, `clr`=0, `en`=1: `q` <= `d`.
- `reset` high, rising `clk`, `clr`=0, `en`=0: `q` keeps its value.
- No combinational path from `d`, `en` or `clr` to `q`.
- All bits are independent. There is no arithmetic and no width conversion. `d` and `q` are exactly WIDTH bits.
- X or Z on `en` or `clr` while `reset` is high must propagate X to `q` in simulation. It must not be silently treated as 0.

## Timing
- Reset value: `q` = RESET_VALUE. With the macro, `q_n` = ~RESET_VALUE.
- Reset assertion: `q` changes with zero clock latency, immediately on the falling edge of `reset`.
- Reset deassertion: the first capture happens on the first rising `clk` edge at which `reset` is already high.
- If `clk` rises at the same time `reset` rises, that edge does not capture; `q` stays RESET_VALUE.
- Latency from `d` to `q` is 1 cycle: a value on `d` before edge N appears on `q` just after edge N.
- Throughput: one new sample per cycle.
- Reset mid-operation: any captured value is lost. There is no partial update.
- `d` changing between edges has no effect on `q`.

## Configuration
- `DFF_QN_OUTPUT_EN` defined: port `q_n` exists and equals ~`q` at all times, including during reset. It is driven from the register, not from a separate flop.
- `DFF_QN_OUTPUT_EN` undefined: port `q_n` and its logic are absent. All other behaviour is identical.

## Structure
- The shared package `dff_pkg` holds:
  - `DFF_MAX_WIDTH` = 64
  - the default reset-value constant
  - a `dff_ctrl_t` typedef packing {`clr`, `en`}
- One sub-module, `dff_bit_cell`, implements one bit: async active-low reset, sync clear, enable, and a per-bit reset value.
- The top instantiates WIDTH cells in a generate loop.
- The top elaborates a parameter check that 1 <= WIDTH <= DFF_MAX_WIDTH.

## Test plan
Clock period 6 ns, WIDTH=1, RESET_VALUE=0 unless stated.
- Async reset: `q`=1, drive `reset` low between edges -> `q`=0 within the same timestep, before any `clk` edge. `q` stays 0 while `reset` is low, with `d`=1 and `en`=1.
- Capture: `reset` high, `en`=1, apply `d` = 1,0,1 on consecutive cycles -> `q` = 1,0,1, each one edge later.
- Enable hold: `q`=1, `en`=0, `d`=0 for 3 edges -> `q` stays 1. Raise `en` -> `q`=0 after the next edge.
- Sync clear priority: `q`=1, `en`=1, `d`=1, `clr`=1 -> `q`=0 after the edge. `clr`=0 -> `q`=1 after the following edge.
- Reset release coinciding with `clk` rise: `d`=1, `en`=1 -> `q` stays 0 on that edge and becomes 1 on the next edge.
- WIDTH=8, RESET_VALUE=8'hA5, `DFF_QN_OUTPUT_EN` defined:
  - during reset -> `q`=8'hA5, `q_n`=8'h5A.
  - after capturing `d`=8'h3C -> `q`=8'h3C, `q_n`=8'hC3.
